// File: rtl/timer_periph_if.sv
// Data-memory port bundle between the CPU (master) and a memory-mapped responder (slave).
// The responder drives combinational read data and an address-hit flag back to the CPU.
interface timer_periph_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_ctrl;
    logic [DATA_W-1:0] mem_rd;
    logic              sel;

    modport master (
        output mem_addr,
        output mem_wd,
        output mem_ctrl,
        input  mem_rd,
        input  sel
    );

    modport slave (
        input  mem_addr,
        input  mem_wd,
        input  mem_ctrl,
        output mem_rd,
        output sel
    );
endinterface

// File: rtl/timer_periph.sv
// Memory-mapped timer/compare peripheral on the CPU data-memory port.
// Eight-word window at BASE_ADDR: CTRL, PRESC, CMP, CNT, STAT, DUTY, two reserved words.
// A prescaler produces ticks; the counter advances per tick, flags MATCH at CMP and
// either reloads (AUTO) or stops (one-shot). MATCH & IE drives one interrupt bus bit.
// Optional feature macro: TIMER_PWM_EN adds the DUTY register and a registered PWM output;
// without it offset 5 is reserved and pwm_o is tied low.
module timer_periph #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                INT_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00,
    parameter int                INT_IDX   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    timer_periph_if.slave      bus,
    output logic [INT_W-1:0]   int_o,
    output logic               pwm_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              auto_q, auto_d;
    logic              ie_q, ie_d;
    logic              match_q, match_d;
    logic [DATA_W-1:0] presc_q, presc_d;
    logic [DATA_W-1:0] cmp_q, cmp_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] pcnt_q, pcnt_d;

    logic [2:0] off;
    logic       wr;
    logic       wr_ctrl, wr_presc, wr_cmp, wr_cnt, wr_stat;
    logic       tick, tick_eff, stop_req;
    logic       en;

    assign off      = bus.mem_addr[2:0];
    assign bus.sel  = (bus.mem_addr[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
    assign wr       = bus.sel & bus.mem_ctrl;
    assign wr_ctrl  = wr && (off == 3'd0);
    assign wr_presc = wr && (off == 3'd1);
    assign wr_cmp   = wr && (off == 3'd2);
    assign wr_cnt   = wr && (off == 3'd3);
    assign wr_stat  = wr && (off == 3'd4);

    // The FSM state doubles as the CTRL.EN bit.
    assign en       = (state_q == RUN);
    assign tick     = en && (pcnt_q == presc_q);
    // A CPU write to CNT, or a stop request, swallows a coincident tick.
    assign stop_req = wr_ctrl & ~bus.mem_wd[0];
    assign tick_eff = tick & ~wr_cnt & ~stop_req;

    assign int_o = INT_W'(match_q & ie_q) << INT_IDX;

`ifdef TIMER_PWM_EN
    logic [DATA_W-1:0] duty_q, duty_d;
    logic              pwm_q, pwm_d;
    logic              wr_duty;

    assign wr_duty = wr && (off == 3'd5);
    assign pwm_o   = pwm_q;

    // DUTY register update and PWM compare, registered one cycle behind CNT
    always_comb begin
        duty_d = duty_q;
        if (wr_duty) duty_d = bus.mem_wd;
        pwm_d = en && (cnt_q < duty_q);
    end

    // DUTY and PWM output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end
`else
    assign pwm_o = 1'b0;
`endif

    // Combinational read mux; zero when the address misses the window
    always_comb begin
        bus.mem_rd = '0;
        if (bus.sel) begin
            case (off)
                3'd0: bus.mem_rd = {{(DATA_W-3){1'b0}}, ie_q, auto_q, en};
                3'd1: bus.mem_rd = presc_q;
                3'd2: bus.mem_rd = cmp_q;
                3'd3: bus.mem_rd = cnt_q;
                3'd4: bus.mem_rd = {{(DATA_W-1){1'b0}}, match_q};
`ifdef TIMER_PWM_EN
                3'd5: bus.mem_rd = duty_q;
`endif
                default: bus.mem_rd = '0;
            endcase
        end
    end

    // Next-state: prescaler, counter FSM, then CPU writes layered on top
    always_comb begin
        state_d = state_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        match_d = match_q;
        presc_d = presc_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        pcnt_d  = '0;

        if (en) pcnt_d = tick ? '0 : pcnt_q + 1'b1;

        // W1C is applied before the tick so a coincident new match keeps MATCH set.
        if (wr_stat && bus.mem_wd[0]) match_d = 1'b0;

        if (tick_eff) begin
            if (cnt_q == cmp_q) begin
                match_d = 1'b1;
                if (auto_q) cnt_d = '0;
                else        state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (wr_ctrl) begin
            state_d = bus.mem_wd[0] ? RUN : IDLE;
            auto_d  = bus.mem_wd[1];
            ie_d    = bus.mem_wd[2];
        end
        if (wr_presc) presc_d = bus.mem_wd;
        if (wr_cmp)   cmp_d   = bus.mem_wd;
        if (wr_cnt)   cnt_d   = bus.mem_wd;

        // Reprogramming the prescaler or stopping restarts the prescale phase.
        if (wr_presc || stop_req) pcnt_d = '0;
    end

    // Register state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            match_q <= 1'b0;
            presc_q <= '0;
            cmp_q   <= '0;
            cnt_q   <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            match_q <= match_d;
            presc_q <= presc_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

endmodule

// File: tb/tb_timer_periph.sv
// Directed bench for timer_periph: a table of bus reads/writes for reset and decode,
// followed by hand-written timing sequences for counting, collisions and reset.
module tb_timer_periph;

    localparam logic [15:0] BASE = 16'hFF00;
`ifdef TIMER_PWM_EN
    localparam logic [15:0] DUTY_RB  = 16'h0077;
    localparam int          PWM_HIGH = 8;
`else
    localparam logic [15:0] DUTY_RB  = 16'h0000;
    localparam int          PWM_HIGH = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] int_o;
    logic       pwm_o;

    int total = 0;
    int bad   = 0;

    timer_periph_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    timer_periph #(
        .DATA_W(16), .ADDR_W(16), .INT_W(8), .BASE_ADDR(BASE), .INT_IDX(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .int_o (int_o),
        .pwm_o (pwm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 read-check, 1 write, 2 drive data with strobe low
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic        exp_sel;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(int k, logic [15:0] a, logic [15:0] d, logic [15:0] e, logic s);
        vec_t v;
        v.kind = k; v.addr = a; v.wd = d; v.exp_rd = e; v.exp_sel = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] d);
        bus.mem_addr = BASE | {13'd0, off};
        bus.mem_wd   = d;
        bus.mem_ctrl = 1'b1;
        step();
        bus.mem_ctrl = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [2:0] off, input logic [15:0] exp);
        bus.mem_addr = BASE | {13'd0, off};
        bus.mem_ctrl = 1'b0;
        #1;
        chk(name, {16'd0, bus.mem_rd}, {16'd0, exp});
    endtask

    task automatic do_reset();
        bus.mem_ctrl = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] seq_auto [6];
        logic [15:0] seq_one  [11];
        int          pwm_cnt;

        bus.mem_addr = '0;
        bus.mem_wd   = '0;
        bus.mem_ctrl = 1'b0;
        rst_n        = 1'b0;
        #3;
        do_reset();

        chk("rst_int", {24'd0, int_o}, 32'h0);
        chk("rst_pwm", {31'd0, pwm_o}, 32'h0);

        // Reset values, decode, strobe gating, reserved and masked bits
        for (int i = 0; i < 8; i++) vq.push_back(mkv(0, BASE + 16'(i), 16'h0, 16'h0, 1'b1));
        vq.push_back(mkv(1, BASE + 16'd2, 16'h1234, 16'h0, 1'b1));
        vq.push_back(mkv(0, BASE + 16'd2, 16'h0, 16'h1234, 1'b1));
        vq.push_back(mkv(0, 16'hFE02, 16'h0, 16'h0, 1'b0));
        vq.push_back(mkv(2, BASE + 16'd2, 16'hABCD, 16'h0, 1'b1));
        vq.push_back(mkv(0, BASE + 16'd2, 16'h0, 16'h1234, 1'b1));
        vq.push_back(mkv(1, BASE + 16'd1, 16'h00AB, 16'h0, 1'b1));
        vq.push_back(mkv(0, BASE + 16'd1, 16'h0, 16'h00AB, 1'b1));
        vq.push_back(mkv(1, BASE + 16'd6, 16'hFFFF, 16'h0, 1'b1));
        vq.push_back(mkv(0, BASE + 16'd6, 16'h0, 16'h0, 1'b1));
        vq.push_back(mkv(1, BASE + 16'd7, 16'hFFFF, 16'h0, 1'b1));
        vq.push_back(mkv(0, BASE + 16'd7, 16'h0, 16'h0, 1'b1));
        vq.push_back(mkv(1, BASE + 16'd0, 16'hFFF8, 16'h0, 1'b1));
        vq.push_back(mkv(0, BASE + 16'd0, 16'h0, 16'h0, 1'b1));
        vq.push_back(mkv(1, BASE + 16'd5, 16'h0077, 16'h0, 1'b1));
        vq.push_back(mkv(0, BASE + 16'd5, 16'h0, DUTY_RB, 1'b1));
        vq.push_back(mkv(1, BASE + 16'd4, 16'h0001, 16'h0, 1'b1));
        vq.push_back(mkv(0, BASE + 16'd4, 16'h0, 16'h0, 1'b1));
        vq.push_back(mkv(0, 16'hFF08, 16'h0, 16'h0, 1'b0));

        foreach (vq[i]) begin
            bus.mem_addr = vq[i].addr;
            bus.mem_wd   = vq[i].wd;
            case (vq[i].kind)
                0: begin
                    bus.mem_ctrl = 1'b0;
                    #1;
                    chk($sformatf("tbl%0d_rd", i), {16'd0, bus.mem_rd}, {16'd0, vq[i].exp_rd});
                    chk($sformatf("tbl%0d_sel", i), {31'd0, bus.sel}, {31'd0, vq[i].exp_sel});
                end
                1: begin
                    bus.mem_ctrl = 1'b1;
                    step();
                    bus.mem_ctrl = 1'b0;
                end
                default: begin
                    bus.mem_ctrl = 1'b0;
                    step();
                end
            endcase
        end

        // Auto-reload, W1C clearing the interrupt, then async reset mid-run
        do_reset();
        seq_auto = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
        wr(3'd1, 16'd0);
        wr(3'd2, 16'd3);
        wr(3'd0, 16'h0007);
        for (int i = 0; i < 6; i++) begin
            chk_reg($sformatf("auto_cnt%0d", i), 3'd3, seq_auto[i]);
            if (i == 3) chk("auto_int_before", {24'd0, int_o}, 32'h0);
            if (i == 4) begin
                chk("auto_int_match", {24'd0, int_o}, 32'h1);
                chk_reg("auto_stat", 3'd4, 16'h1);
            end
            step();
        end
        wr(3'd4, 16'h0001);
        chk("auto_int_cleared", {24'd0, int_o}, 32'h0);
        chk_reg("auto_cnt_after_w1c", 3'd3, 16'd3);
        step();
        chk("auto_int_rematch", {24'd0, int_o}, 32'h1);
        chk_reg("auto_cnt_reload", 3'd3, 16'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_int", {24'd0, int_o}, 32'h0);
        chk_reg("rst_async_cnt", 3'd3, 16'd0);
        chk_reg("rst_async_ctrl", 3'd0, 16'd0);
        step();
        rst_n = 1'b1;
        step();

        // One-shot with prescale of 3, interrupt enabled
        do_reset();
        seq_one = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2};
        wr(3'd1, 16'd2);
        wr(3'd2, 16'd2);
        wr(3'd0, 16'h0005);
        for (int k = 0; k < 11; k++) begin
            chk_reg($sformatf("os_cnt%0d", k), 3'd3, seq_one[k]);
            if (k == 8) chk_reg("os_ctrl_running", 3'd0, 16'h0005);
            if (k == 9) begin
                chk_reg("os_ctrl_stopped", 3'd0, 16'h0004);
                chk_reg("os_stat", 3'd4, 16'h0001);
                chk("os_int", {24'd0, int_o}, 32'h1);
            end
            step();
        end

        // One-shot with IE clear: MATCH set but no interrupt
        do_reset();
        wr(3'd1, 16'd2);
        wr(3'd2, 16'd2);
        wr(3'd0, 16'h0001);
        for (int k = 0; k < 10; k++) step();
        chk_reg("noie_stat", 3'd4, 16'h0001);
        chk_reg("noie_ctrl", 3'd0, 16'h0000);
        chk("noie_int", {24'd0, int_o}, 32'h0);

        // CNT write on a tick cycle wins over the increment
        do_reset();
        wr(3'd1, 16'd0);
        wr(3'd2, 16'h0100);
        wr(3'd0, 16'h0001);
        wr(3'd3, 16'h00FF);
        chk_reg("coll_cnt_write", 3'd3, 16'h00FF);
        step();
        chk_reg("coll_cnt_next", 3'd3, 16'h0100);
        chk_reg("coll_stat_pre", 3'd4, 16'h0000);
        step();
        chk_reg("coll_stat_match", 3'd4, 16'h0001);

        // W1C landing on the match edge leaves MATCH set; a later W1C clears it
        do_reset();
        wr(3'd1, 16'd0);
        wr(3'd2, 16'd2);
        wr(3'd0, 16'h0003);
        step();
        step();
        wr(3'd4, 16'h0001);
        chk_reg("w1c_coll_stat", 3'd4, 16'h0001);
        wr(3'd4, 16'h0001);
        chk_reg("w1c_clear_stat", 3'd4, 16'h0000);

        // Counter written above CMP wraps silently and matches on the way back up
        do_reset();
        wr(3'd1, 16'd0);
        wr(3'd2, 16'd1);
        wr(3'd3, 16'hFFFF);
        wr(3'd0, 16'h0001);
        chk_reg("wrap_start", 3'd3, 16'hFFFF);
        step();
        chk_reg("wrap_zero", 3'd3, 16'h0000);
        step();
        chk_reg("wrap_one", 3'd3, 16'h0001);
        chk_reg("wrap_stat_pre", 3'd4, 16'h0000);
        step();
        chk_reg("wrap_stat_match", 3'd4, 16'h0001);
        chk_reg("wrap_ctrl_stop", 3'd0, 16'h0000);
        chk_reg("wrap_cnt_hold", 3'd3, 16'h0001);

        // Clearing EN while running freezes CNT on that edge
        do_reset();
        wr(3'd1, 16'd0);
        wr(3'd2, 16'd100);
        wr(3'd0, 16'h0001);
        step();
        wr(3'd0, 16'h0000);
        chk_reg("stop_cnt", 3'd3, 16'd1);
        step();
        chk_reg("stop_cnt_hold", 3'd3, 16'd1);

        // PWM: CMP=9, DUTY=4, auto-reload -> high 4 of every 10 cycles
        do_reset();
        wr(3'd1, 16'd0);
        wr(3'd2, 16'd9);
        wr(3'd5, 16'd4);
        wr(3'd0, 16'h0003);
        step();
        step();
        step();
        pwm_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (pwm_o) pwm_cnt++;
            step();
        end
        chk("pwm_high_count", 32'(pwm_cnt), 32'(PWM_HIGH));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
